sda_to_par: RTL and testbench
=============================

# sda_to_par

Serial-to-parallel receiver for the two-wire scl/sda link driven by the team's parallel-to-serial transmitter. It oversamples scl and sda on the system clock and detects start and stop conditions. It shifts in a DATA_W-bit word, MSB first, and presents the word with a one-cycle valid pulse and a held one-hot decode. It sits at the far end of the link and feeds downstream display/decode logic.

## Interface
- DATA_W, 4: data bits per frame; one-hot width is 2**DATA_W.
- TIMEOUT, 64: sclk cycles without any scl edge before an open frame is aborted; ≥4.
- sclk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- scl  in  1  serial clock from the transmitter; toggles at most once per sclk.
- sda  in  1  serial data from the transmitter.
- data_out  out  DATA_W  last good word; held until the next good frame.
- data_valid  out  1  one-cycle pulse when data_out updates.
- onehot  out  2**DATA_W  bit[data_out] set; held.
- frame_err  out  1  one-cycle pulse on a short frame or timeout.
- busy  out  1  high while a frame is open (state ≠ IDLE).

## Operation
- Sample registers: s_scl/s_sda hold the current sample, p_scl/p_sda hold the previous sample.
- start = p_scl & s_scl & p_sda & ~s_sda.
- stop = p_scl & s_scl & ~p_sda & s_sda.
- rise = ~p_scl & s_scl. On rise, bit = s_sda.
- States: IDLE, SHIFT, WAIT_STOP.
  - IDLE: start → SHIFT, bit counter = 0, timeout counter = 0. Stop and rise are ignored.
  - SHIFT: on rise, shift s_sda into the LSB of the shift register (MSB arrives first) and increment the counter. When the counter reaches DATA_W-1 on a rise → WAIT_STOP.
  - WAIT_STOP: stop → IDLE. On this transition, data_out ← shift register, onehot ← 1<<shift register, and data_valid is pulsed.
  - WAIT_STOP: an extra rise beyond DATA_W bits is ignored.
- Stop while in SHIFT (fewer than DATA_W bits): pulse frame_err → IDLE. data_out and onehot are unchanged.
- Start in SHIFT or WAIT_STOP (repeated start): discard the partial word, restart SHIFT with counter 0, and raise no error.
- Timeout: in SHIFT or WAIT_STOP, the counter clears on any scl edge. When it reaches TIMEOUT-1: pulse frame_err → IDLE.
- Precedence within one cycle: start > stop > rise > timeout.
- Reset values:
  - data_out = 0, onehot = 0, data_valid = 0, frame_err = 0, busy = 0, state = IDLE.
  - Sample registers are set to 1, so no edge is detected on the first cycle after reset.
- rst high mid-frame aborts the frame without a frame_err pulse.

## Timing
- All outputs are registered.
- data_valid and frame_err rise one sclk after the posedge at which the stop or error condition is sampled.
- busy rises one sclk after the start sample.
- Without the synchronizer, end-to-end latency from the sda rise of the stop condition to data_valid is 2 sclk posedges. P2S_RX_SYNC_EN adds 2 to this.
- Minimum frame spacing: a start may be sampled in the cycle immediately after data_valid is pulsed. Back-to-back frames produce no gaps in acceptance.
- scl low or high phase must span ≥1 sclk sample. Shorter phases are outside the spec and not checked.

## Configuration
- P2S_RX_SYNC_EN defined: scl and sda each pass through a two-flop synchronizer, reset to 1, before the sample registers. This is for asynchronous or off-chip links. Latency +2 sclk, and the TIMEOUT count is unaffected.
- P2S_RX_SYNC_EN undefined: scl and sda feed the sample registers directly. This is for the same-clock link.

## Structure
- Package p2s_pkg holds:
  - the state enum (IDLE, SHIFT, WAIT_STOP);
  - default DATA_W and TIMEOUT constants;
  - a function returning the one-hot of a DATA_W word.
- Sub-module p2s_edge_det contains:
  - the optional synchronizer;
  - the sample registers;
  - start/stop/rise outputs plus an any-scl-edge output.
- The top module holds the FSM, counters, shift register and output registers.

## Test plan
- Frame 1011 via start, 4 bits, stop → data_out=4'hB, onehot=16'h0800, data_valid high for exactly 1 cycle, frame_err=0.
- Back-to-back frames 0000 then 1111 → data_out 4'h0 then 4'hF, onehot 16'h0001 then 16'h8000, two valid pulses.
- Start, 2 bits (10), stop → frame_err one pulse; data_out and onehot keep their previous values; busy falls.
- Start, 3 bits, repeated start, 0110, stop → data_out=4'h6, no frame_err.
- Start, 2 bits, then scl held for TIMEOUT cycles → frame_err at cycle TIMEOUT; next full frame 0101 → data_out=4'h5.
- rst pulsed mid-frame → all outputs 0 next cycle, no frame_err; a following frame 1001 decodes to 4'h9. Repeat the scenario set with P2S_RX_SYNC_EN defined and check latency +2.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared types and helpers for the scl/sda serial-to-parallel receiver.
// The default build omits the input synchronizer. Define P2S_RX_SYNC_EN to add it.
package p2s_pkg;

    localparam int DATA_W_DEF  = 4;
    localparam int TIMEOUT_DEF = 64;
    // Widest one-hot the helper can produce, so DATA_W is limited to 8.
    localparam int OH_MAX      = 256;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_STOP
    } p2s_state_e;

    function automatic logic [OH_MAX-1:0] onehot_of(input logic [7:0] word);
        logic [OH_MAX-1:0] oh;
        oh       = '0;
        oh[word] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/p2s_edge_det.sv
// Samples scl/sda and decodes start, stop, scl rise and any scl edge.
// The two-flop input synchronizer is present only when P2S_RX_SYNC_EN is defined.
module p2s_edge_det (
    input  logic sclk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic start,
    output logic stop,
    output logic rise,
    output logic scl_edge,
    output logic bit_val
);

    logic scl_in, sda_in;
    logic s_scl, s_sda, p_scl, p_sda;

`ifdef P2S_RX_SYNC_EN
    logic [1:0] scl_sync, sda_sync;

    always_ff @(posedge sclk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

    assign scl_in = scl_sync[1];
    assign sda_in = sda_sync[1];
`else
    assign scl_in = scl;
    assign sda_in = sda;
`endif

    // Reset to the idle-bus level so the first cycle after reset shows no edge.
    always_ff @(posedge sclk) begin
        if (rst) begin
            s_scl <= 1'b1;
            s_sda <= 1'b1;
            p_scl <= 1'b1;
            p_sda <= 1'b1;
        end else begin
            s_scl <= scl_in;
            s_sda <= sda_in;
            p_scl <= s_scl;
            p_sda <= s_sda;
        end
    end

    assign start    = p_scl & s_scl & p_sda & ~s_sda;
    assign stop     = p_scl & s_scl & ~p_sda & s_sda;
    assign rise     = ~p_scl & s_scl;
    assign scl_edge = p_scl ^ s_scl;
    assign bit_val  = s_sda;

endmodule

// File: rtl/sda_to_par.sv
// Serial-to-parallel receiver for the scl/sda link: frame FSM, bit and timeout counters,
// shift register and registered outputs. P2S_RX_SYNC_EN enables the input synchronizer.
module sda_to_par
    import p2s_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 sclk,
    input  logic                 rst,
    input  logic                 scl,
    input  logic                 sda,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic [2**DATA_W-1:0] onehot,
    output logic                 frame_err,
    output logic                 busy,
    output p2s_state_e           state_dbg
);

    localparam int OH_W = 2**DATA_W;
    localparam int CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TW   = $clog2(TIMEOUT);

    logic start, stop, rise, scl_edge, bit_val;

    p2s_edge_det u_edge (
        .sclk     (sclk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .start    (start),
        .stop     (stop),
        .rise     (rise),
        .scl_edge (scl_edge),
        .bit_val  (bit_val)
    );

    p2s_state_e        state, state_n;
    logic [CW-1:0]     bit_cnt, bit_cnt_n;
    logic [TW-1:0]     to_cnt, to_cnt_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic              load, err;

    // data_valid has no ready: it is a one-cycle pulse that downstream must take when it
    // sees it, while data_out and onehot hold their value until the next good frame.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        to_cnt_n  = to_cnt;
        shift_n   = shift_q;
        load      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SHIFT;
                    bit_cnt_n = '0;
                    to_cnt_n  = '0;
                    shift_n   = '0;
                end
            end
            SHIFT, WAIT_STOP: begin
                if (start) begin
                    state_n   = SHIFT;
                    bit_cnt_n = '0;
                    to_cnt_n  = '0;
                    shift_n   = '0;
                end else if (stop) begin
                    load    = (state == WAIT_STOP);
                    err     = (state == SHIFT);
                    state_n = IDLE;
                end else if (rise) begin
                    to_cnt_n = '0;
                    if (state == SHIFT) begin
                        shift_n   = {shift_q[DATA_W-2:0], bit_val};
                        bit_cnt_n = bit_cnt + CW'(1);
                        if (bit_cnt == CW'(DATA_W-1))
                            state_n = WAIT_STOP;
                    end
                end else if (scl_edge) begin
                    to_cnt_n = '0;
                end else if (to_cnt == TW'(TIMEOUT-1)) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end else begin
                    to_cnt_n = to_cnt + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            shift_q    <= '0;
            data_out   <= '0;
            onehot     <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            to_cnt     <= to_cnt_n;
            shift_q    <= shift_n;
            data_valid <= load;
            frame_err  <= err;
            busy       <= (state_n != IDLE);
            if (load) begin
                data_out <= shift_q;
                onehot   <= OH_W'(onehot_of(8'(shift_q)));
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_sda_to_par.sv
// Self-checking bench for sda_to_par: drives scl/sda frames and scoreboards decoded words.
// Build with P2S_RX_SYNC_EN defined to exercise the synchronized variant.
module tb_sda_to_par;
    import p2s_pkg::*;

    localparam int DATA_W  = 4;
    localparam int TIMEOUT = 64;
    localparam int HOLD    = 2;
`ifdef P2S_RX_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = 2 + SYNC;

    logic              sclk = 1'b0;
    logic              rst  = 1'b1;
    logic              scl  = 1'b1;
    logic              sda  = 1'b1;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [15:0]       onehot;
    logic              frame_err;
    logic              busy;
    p2s_state_e        state_dbg;

    sda_to_par #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .sclk       (sclk),
        .rst        (rst),
        .scl        (scl),
        .sda        (sda),
        .data_out   (data_out),
        .data_valid (data_valid),
        .onehot     (onehot),
        .frame_err  (frame_err),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // clock / cycle counter
    always #5 sclk = ~sclk;
    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;
    int n_valid = 0, err_seen = 0, err_cyc = 0, stop_cyc = 0, edge_cyc = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic              prev_valid = 1'b0, prev_err = 1'b0;
    logic [DATA_W-1:0] mon_w;
    logic [15:0]       mon_oh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard: every data_valid pops one expected word
    always @(negedge sclk) begin
        if (!rst) begin
            if (data_valid) begin
                n_valid++;
                check("valid_width", 32'(prev_valid), 0);
                check("latency", 32'(cyc - stop_cyc), LAT);
                check("q_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_w         = exp_q.pop_front();
                    mon_oh        = '0;
                    mon_oh[mon_w] = 1'b1;
                    check("sb_data", 32'(data_out), 32'(mon_w));
                    check("sb_onehot", 32'(onehot), 32'(mon_oh));
                end
            end
            if (frame_err) begin
                err_seen++;
                err_cyc = cyc;
                check("err_width", 32'(prev_err), 0);
            end
        end
        prev_valid = data_valid;
        prev_err   = frame_err;
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic set(input logic c, input logic d);
        if (c !== scl) edge_cyc = cyc;
        scl = c;
        sda = d;
        tick(HOLD);
    endtask

    task automatic send_start();
        if (scl == 1'b0) set(1'b0, 1'b1);
        set(1'b1, 1'b1);
        set(1'b1, 1'b0);
        set(1'b0, 1'b0);
    endtask

    task automatic send_bit(input logic b);
        set(1'b0, b);
        set(1'b1, b);
        set(1'b0, b);
    endtask

    task automatic send_stop();
        set(1'b0, 1'b0);
        set(1'b1, 1'b0);
        stop_cyc = cyc;
        sda      = 1'b1;
        tick(HOLD);
    endtask

    task automatic send_bits(input logic [DATA_W-1:0] w);
        for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w);
        send_start();
        send_bits(w);
        exp_q.push_back(w);
        send_stop();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(data_out),   0);
        check({tag, "_oh"},    32'(onehot),     0);
        check({tag, "_valid"}, 32'(data_valid), 0);
        check({tag, "_err"},   32'(frame_err),  0);
        check({tag, "_busy"},  32'(busy),       0);
        check({tag, "_state"}, 32'(state_dbg),  32'(IDLE));
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        tick(3);
        check_reset_outputs("rst");
        rst = 1'b0;
        tick(2);

        send_frame(4'b1011);
        tick(4 + SYNC);
        check("f1_data", 32'(data_out), 32'h000B);
        check("f1_oh", 32'(onehot), 32'h0800);
        check("f1_noerr", 32'(err_seen), 0);

        send_frame(4'b0000);
        send_frame(4'b1111);
        tick(4 + SYNC);
        check("b2b_data", 32'(data_out), 32'h000F);
        check("b2b_oh", 32'(onehot), 32'h8000);

        send_start();
        send_bit(1'b1);
        send_bit(1'b0);
        check("short_busy", 32'(busy), 1);
        send_stop();
        tick(4 + SYNC);
        check("short_err", 32'(err_seen), 1);
        check("short_hold_data", 32'(data_out), 32'h000F);
        check("short_hold_oh", 32'(onehot), 32'h8000);
        check("short_busy_fall", 32'(busy), 0);

        send_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_start();
        send_bits(4'b0110);
        exp_q.push_back(4'b0110);
        send_stop();
        tick(4 + SYNC);
        check("rep_data", 32'(data_out), 32'h0006);
        check("rep_noerr", 32'(err_seen), 1);

        send_start();
        send_bit(1'b1);
        send_bit(1'b0);
        t0 = edge_cyc;
        for (int i = 0; i < TIMEOUT + 20 && err_seen < 2; i++) tick(1);
        check("to_err", 32'(err_seen), 2);
        check("to_lat", 32'(err_cyc - t0), TIMEOUT + 2 + SYNC);
        tick(1);
        check("to_busy", 32'(busy), 0);
        send_frame(4'b0101);
        tick(4 + SYNC);
        check("to_next_data", 32'(data_out), 32'h0005);

        send_start();
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick(2);
        send_frame(4'b1001);
        tick(4 + SYNC);
        check("rst_next_data", 32'(data_out), 32'h0009);
        check("rst_next_oh", 32'(onehot), 32'h0200);

        tick(10);
        check("end_err_cnt", 32'(err_seen), 2);
        check("end_valid_cnt", 32'(n_valid), 6);
        check("end_q_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
